// File: rtl/iod_clk_train_pkg.sv
// Shared types and default constants for the IOD clock-training sequencer.
// The FSM state encoding lives here so the top and any debug tooling agree on it.
package iod_clk_train_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    CLEAR,
    SAMPLE,
    EVAL,
    STEP,
    CENTER_CALC,
    CENTER_MOVE,
    NEXT,
    DONE
  } train_state_t;

  localparam int unsigned DEF_NUM_LANES     = 4;
  localparam int unsigned DEF_TAP_W         = 7;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_SAMPLE_CYCLES = 16;
  localparam int unsigned DEF_MIN_EYE       = 4;
  localparam logic [2:0]  DEF_EM_WIDTH      = 3'b001;

  // Larger of two cycle counts; sizes the shared settle/sample counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iod_eye_run_tracker.sv
// Longest-clean-run tracker for one tap sweep.
// Each valid strobe presents one tap's verdict. A clean tap extends the open
// run; a dirty tap closes it. The best run is replaced only on a strictly
// longer length, so among equal runs the earliest one is kept. Because the
// best is refreshed while a run grows, a run still open at the end of the
// sweep is already accounted for. Lengths use TAP_W+1 bits so a run covering
// every tap does not wrap.
module iod_eye_run_tracker #(
  parameter int unsigned TAP_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic             clean,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W:0]   best_start,
  output logic [TAP_W:0]   best_len
);

  localparam logic [TAP_W:0] LEN_ONE = (TAP_W+1)'(1);

  logic [TAP_W:0] cur_start;
  logic [TAP_W:0] cur_len;
  logic [TAP_W:0] ext_start;
  logic [TAP_W:0] ext_len;

  // Candidate run if the current tap turns out clean.
  always_comb begin
    ext_start = cur_start;
    if (cur_len == '0) begin
      ext_start = {1'b0, tap};
    end
    ext_len = cur_len + LEN_ONE;
  end

  // Open-run and best-run registers, wiped at the start of each lane sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      if (clean) begin
        cur_start <= ext_start;
        cur_len   <= ext_len;
        if (ext_len > best_len) begin
          best_start <= ext_start;
          best_len   <= ext_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/iod_clk_train_ctrl.sv
// Multi-lane clock-training sequencer for IOD receive lanes with the eye
// monitor enabled. Lanes are trained one after another: the delay line is
// swept upward tap by tap, the early/late flags are accumulated at every tap,
// and the lane is finally parked at the centre of its longest clean run.
// Lanes whose best run is shorter than MIN_EYE are flagged in TRAIN_ERR and
// reloaded to tap 0.
// Optional build macro CLK_TRAIN_EYE_REPORT_EN adds the EYE_WIDTH output
// (per-lane best run length).
module iod_clk_train_ctrl
  import iod_clk_train_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DEF_NUM_LANES,
  parameter int unsigned TAP_W         = DEF_TAP_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int unsigned MIN_EYE       = DEF_MIN_EYE,
  parameter logic [2:0]  EM_WIDTH      = DEF_EM_WIDTH
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  input  logic                         TRAIN_START,
  output logic                         TRAIN_BUSY,
  output logic                         TRAIN_DONE,
  output logic [NUM_LANES-1:0]         TRAIN_ERR,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_LATE,
  output logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS,
  output logic [2:0]                   EYE_MONITOR_LANE_WIDTH,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
`ifdef CLK_TRAIN_EYE_REPORT_EN
  output logic [NUM_LANES*(TAP_W+1)-1:0] EYE_WIDTH,
`endif
  output logic [NUM_LANES*TAP_W-1:0]   LANE_TAP
);

  localparam int unsigned LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_MAX = max2(SETTLE_CYCLES, SAMPLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [TAP_W-1:0]  TAP_LAST    = '1;
  localparam logic [TAP_W-1:0]  TAP_ONE     = TAP_W'(1);
  localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
  localparam logic [LANE_W-1:0] LANE_ONE    = LANE_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [TAP_W:0]    MIN_EYE_LEN = (TAP_W+1)'(MIN_EYE);

  train_state_t state;
  train_state_t state_nxt;

  logic [LANE_W-1:0]    lane;
  logic [TAP_W-1:0]     tap;
  logic [CNT_W-1:0]     cnt;
  logic                 dirty;
  logic                 phase;
  logic [NUM_LANES-1:0] lane_sel;
  logic                 lane_flag;
  logic                 lane_oor;
  logic [TAP_W:0]       best_start;
  logic [TAP_W:0]       best_len;
  logic [TAP_W:0]       centre;
  logic                 at_centre;
  logic                 eye_fail;

  assign EYE_MONITOR_LANE_WIDTH = EM_WIDTH;

  iod_eye_run_tracker #(
    .TAP_W (TAP_W)
  ) u_tracker (
    .clk        (FAB_CLK),
    .rst_n      (ARST_N),
    .clear      (state == LOAD),
    .valid      (state == EVAL),
    .clean      (!dirty),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  // Per-lane selection, centre arithmetic and lane-pass decision.
  always_comb begin
    lane_sel       = '0;
    lane_sel[lane] = 1'b1;
    lane_flag      = EYE_MONITOR_EARLY[lane] | EYE_MONITOR_LATE[lane];
    lane_oor       = DELAY_LINE_OUT_OF_RANGE[lane];
    centre         = best_start + (best_len >> 1);
    at_centre      = ({1'b0, tap} == centre);
    eye_fail       = (best_len < MIN_EYE_LEN);
  end

  // FSM state register.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and single-cycle strobes for the selected lane.
  always_comb begin
    state_nxt               = state;
    TRAIN_BUSY              = (state != IDLE);
    TRAIN_DONE              = 1'b0;
    EYE_MONITOR_CLEAR_FLAGS = '0;
    DELAY_LINE_LOAD         = '0;
    DELAY_LINE_MOVE         = '0;
    DELAY_LINE_DIRECTION    = '0;
    case (state)
      IDLE: begin
        if (TRAIN_START) state_nxt = LOAD;
      end
      LOAD: begin
        DELAY_LINE_LOAD = lane_sel;
        state_nxt       = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = CLEAR;
      end
      CLEAR: begin
        EYE_MONITOR_CLEAR_FLAGS = lane_sel;
        state_nxt               = SAMPLE;
      end
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) state_nxt = EVAL;
      end
      EVAL: begin
        if ((tap == TAP_LAST) || lane_oor) state_nxt = CENTER_CALC;
        else                               state_nxt = STEP;
      end
      STEP: begin
        DELAY_LINE_MOVE      = lane_sel;
        DELAY_LINE_DIRECTION = lane_sel;
        state_nxt            = SETTLE;
      end
      CENTER_CALC: begin
        if (eye_fail) begin
          DELAY_LINE_LOAD = lane_sel;
          state_nxt       = NEXT;
        end else begin
          state_nxt = CENTER_MOVE;
        end
      end
      CENTER_MOVE: begin
        if (at_centre) begin
          state_nxt = NEXT;
        end else if (!phase) begin
          DELAY_LINE_MOVE = lane_sel;
        end
      end
      NEXT: begin
        if (lane == LANE_LAST) state_nxt = DONE;
        else                   state_nxt = LOAD;
      end
      DONE: begin
        TRAIN_DONE = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep datapath: lane/tap tracking, cycle counting, flag accumulation, results.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      lane      <= '0;
      tap       <= '0;
      cnt       <= '0;
      dirty     <= 1'b0;
      phase     <= 1'b0;
      TRAIN_ERR <= '0;
      LANE_TAP  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (TRAIN_START) begin
            TRAIN_ERR <= '0;
            lane      <= '0;
          end
        end
        LOAD: begin
          tap <= '0;
          cnt <= '0;
        end
        SETTLE: begin
          cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + CNT_ONE;
        end
        CLEAR: begin
          dirty <= 1'b0;
          cnt   <= '0;
        end
        SAMPLE: begin
          dirty <= dirty | lane_flag;
          cnt   <= (cnt == SAMPLE_LAST) ? '0 : cnt + CNT_ONE;
        end
        STEP: begin
          tap <= tap + TAP_ONE;
        end
        CENTER_CALC: begin
          phase <= 1'b0;
          if (eye_fail) begin
            TRAIN_ERR[lane] <= 1'b1;
            tap             <= '0;
          end
        end
        CENTER_MOVE: begin
          if (!at_centre) begin
            if (!phase) tap <= tap - TAP_ONE;
            phase <= !phase;
          end
        end
        NEXT: begin
          LANE_TAP[lane*TAP_W +: TAP_W] <= tap;
          if (lane != LANE_LAST) lane <= lane + LANE_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_TRAIN_EYE_REPORT_EN
  // Per-lane best clean-run length, captured as each lane completes.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      EYE_WIDTH <= '0;
    end else if (state == NEXT) begin
      EYE_WIDTH[lane*(TAP_W+1) +: (TAP_W+1)] <= best_len;
    end
  end
`else
  // Eye-width reporting not built; best_len is consumed only by the centre logic.
`endif

endmodule
